// File: rtl/keypad_pkg.sv
// Shared types and constants for the keypad lock controller.
package keypad_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ENTRY   = 3'd1,
    ST_CHECK   = 3'd2,
    ST_OPEN    = 3'd3,
    ST_DENY    = 3'd4,
    ST_LOCKOUT = 3'd5,
    ST_PROG    = 3'd6
  } state_e;

  localparam logic [3:0] KEY_CLR  = 4'hA;
  localparam logic [3:0] KEY_PROG = 4'hB;
  localparam logic [3:0] KEY_BS   = 4'hE;
  localparam logic [3:0] KEY_ENT  = 4'hF;

  // Clock cycles spanned by a given number of milliseconds.
  function automatic int unsigned ms_to_ticks(input int unsigned clk_hz, input int unsigned ms);
    return (clk_hz / 1000) * ms;
  endfunction

endpackage

// File: rtl/keypad_ms_tick.sv
// Free-running divider: one-cycle tick every DIV clocks.
module keypad_ms_tick #(
  parameter int unsigned DIV = 50_000
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);
  localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] cnt;

  assign tick = (cnt == CW'(DIV - 1));

  always_ff @(posedge clk) begin
    if (!rst_n)    cnt <= '0;
    else if (tick) cnt <= '0;
    else           cnt <= cnt + CW'(1);
  end
endmodule

// File: rtl/keypad_lock_ctrl.sv
// Keypad lock sequencer: entry buffer, password store, attempt counter and ms timers.
module keypad_lock_ctrl
  import keypad_pkg::*;
#(
  parameter int unsigned CLK_FREQ_HZ      = 50_000_000,
  parameter int unsigned PW_LEN           = 5,
  parameter logic [4*PW_LEN-1:0] DEFAULT_PW = 20'h14321,
  parameter int unsigned MAX_ATTEMPTS     = 3,
  parameter int unsigned UNLOCK_MS        = 5000,
  parameter int unsigned DENY_MS          = 1000,
  parameter int unsigned LOCKOUT_MS       = 30000,
  parameter int unsigned ENTRY_TIMEOUT_MS = 10000
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       key_valid,
  input  logic [3:0] key_code,
  output logic       unlock,
  output logic       deny,
  output logic       lockout,
  output logic       prog_mode,
  output logic [3:0] digit_cnt,
  output logic [3:0] last_digit,
  output logic [3:0] fail_cnt,
  output logic [2:0] state_o
);
  localparam int unsigned T_A   = (UNLOCK_MS > DENY_MS) ? UNLOCK_MS : DENY_MS;
  localparam int unsigned T_B   = (LOCKOUT_MS > ENTRY_TIMEOUT_MS) ? LOCKOUT_MS : ENTRY_TIMEOUT_MS;
  localparam int unsigned T_MAX = (T_A > T_B) ? T_A : T_B;
  localparam int unsigned TW    = $clog2(T_MAX + 1);

  state_e                   state, state_n;
  logic [PW_LEN-1:0][3:0]   ebuf, ebuf_d, pw, pw_d;
  logic [3:0]               cnt, cnt_n, fail, fail_n, fail_inc;
  logic [TW-1:0]            ms_cnt, limit;
  logic                     tick, timed, expire, restart, is_digit;

  keypad_ms_tick #(.DIV(ms_to_ticks(CLK_FREQ_HZ, 1))) u_tick (
    .clk   (CLK),
    .rst_n (RST_N),
    .tick  (tick)
  );

  assign is_digit = (key_code <= 4'd9);
  assign fail_inc = (fail == 4'hF) ? fail : fail + 4'd1;
  assign timed    = (state != ST_IDLE) && (state != ST_CHECK);

  always_comb begin
    case (state)
      ST_OPEN:    limit = TW'(UNLOCK_MS);
      ST_DENY:    limit = TW'(DENY_MS);
      ST_LOCKOUT: limit = TW'(LOCKOUT_MS);
      default:    limit = TW'(ENTRY_TIMEOUT_MS);
    endcase
  end

  // Expiry is evaluated before key handling so a same-cycle key loses.
  assign expire = timed && tick && (ms_cnt >= limit - TW'(1));

  always_comb begin
    state_n = state;
    ebuf_d  = ebuf;
    pw_d    = pw;
    cnt_n   = cnt;
    fail_n  = fail;
    restart = 1'b0;
    case (state)
      ST_IDLE:
        if (key_valid && is_digit) begin
          ebuf_d[0] = key_code;
          cnt_n     = 4'd1;
          state_n   = ST_ENTRY;
        end
      ST_ENTRY, ST_PROG:
        if (expire) begin
          ebuf_d  = '1;
          cnt_n   = '0;
          state_n = ST_IDLE;
        end else if (key_valid) begin
          if (is_digit) begin
            if (cnt < 4'(PW_LEN)) begin
              for (int i = 0; i < PW_LEN; i++)
                if (i == int'(cnt)) ebuf_d[i] = key_code;
              cnt_n   = cnt + 4'd1;
              restart = 1'b1;
            end
          end else if (key_code == KEY_BS) begin
            if (cnt != 4'd0) begin
              for (int i = 0; i < PW_LEN; i++)
                if (i + 1 == int'(cnt)) ebuf_d[i] = 4'hF;
              cnt_n   = cnt - 4'd1;
              restart = 1'b1;
            end
          end else if (key_code == KEY_CLR) begin
            ebuf_d  = '1;
            cnt_n   = '0;
            state_n = (state == ST_ENTRY) ? ST_IDLE : ST_OPEN;
          end else if (key_code == KEY_ENT) begin
            if (state == ST_PROG) begin
              if (cnt == 4'(PW_LEN)) pw_d = ebuf;
              ebuf_d  = '1;
              cnt_n   = '0;
              state_n = ST_OPEN;
            end else if (cnt == 4'(PW_LEN)) begin
              state_n = ST_CHECK;
            end else begin
              ebuf_d  = '1;
              cnt_n   = '0;
              fail_n  = fail_inc;
              state_n = ST_DENY;
            end
          end
        end
      // Buffer is held through CHECK so the compare sees the full entry.
      ST_CHECK: begin
        ebuf_d = '1;
        cnt_n  = '0;
        if (ebuf == pw) begin
          fail_n  = '0;
          state_n = ST_OPEN;
        end else begin
          fail_n  = fail_inc;
          state_n = ST_DENY;
        end
      end
      ST_OPEN:
        if (expire) state_n = ST_IDLE;
        else if (key_valid && key_code == KEY_PROG) begin
          ebuf_d  = '1;
          cnt_n   = '0;
          state_n = ST_PROG;
        end
      ST_DENY:
        if (expire) state_n = (fail >= 4'(MAX_ATTEMPTS)) ? ST_LOCKOUT : ST_IDLE;
      ST_LOCKOUT:
        if (expire) begin
          fail_n  = '0;
          state_n = ST_IDLE;
        end
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state  <= ST_IDLE;
      ebuf   <= '1;
      pw     <= DEFAULT_PW;
      cnt    <= '0;
      fail   <= '0;
      ms_cnt <= '0;
    end else begin
      state <= state_n;
      ebuf  <= ebuf_d;
      pw    <= pw_d;
      cnt   <= cnt_n;
      fail  <= fail_n;
      if (state_n != state || restart) ms_cnt <= '0;
      else if (tick && ms_cnt != '1)   ms_cnt <= ms_cnt + TW'(1);
    end
  end

  always_comb begin
    last_digit = 4'hF;
    for (int i = 0; i < PW_LEN; i++)
      if (i + 1 == int'(cnt)) last_digit = ebuf[i];
  end

  assign unlock    = (state == ST_OPEN) || (state == ST_PROG);
  assign deny      = (state == ST_DENY);
  assign lockout   = (state == ST_LOCKOUT);
  assign prog_mode = (state == ST_PROG);
  assign digit_cnt = cnt;
  assign fail_cnt  = fail;
  assign state_o   = state;
endmodule
